nabp_angle_sequencer: RTL

//  Upstream state control for the NABP shifter. Steps a projection-angle index 0..ANGLE_LEN-1
//  and, for each angle, loads that angle's fixed-point accumulator base from a ROM.
//  It then runs the shifter through one fill/shift pass with a kick/done handshake.

---
 rtl/nabp_pkg.sv | 28 ++
 rtl/nabp_angle_sequencer_if.sv | 27 ++
 rtl/nabp_accu_base_rom.sv | 29 ++
 rtl/nabp_angle_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/nabp_pkg.sv
// Shared NABP types and constants used by the angle sequencer, shifter and mapper.
// The accumulator base is fixed point with ACCU_FRAC fractional bits.
package nabp_pkg;

    localparam int ANGLE_W   = 8;
    localparam int ACCU_W    = 16;
    localparam int ACCU_FRAC = 12;

    typedef logic signed [ACCU_W-1:0] t_accu;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_LATCH,
        S_FILL_KICK,
        S_FILL_WAIT,
        S_SHIFT_KICK,
        S_SHIFT_WAIT,
        S_NEXT,
        S_DONE
    } t_angle_seq_state;

    // Integer value in accumulator fixed-point format (1.0 == 1 << ACCU_FRAC).
    function automatic t_accu accu_from_int(input int v);
        return t_accu'(v <<< ACCU_FRAC);
    endfunction

endpackage

// File: rtl/nabp_angle_sequencer_if.sv
// Sequencer-to-shifter handshake: kick pulses and accumulator base out, done pulses back.
interface nabp_angle_sequencer_if;
    import nabp_pkg::*;

    logic  sh_fill_kick;
    logic  sh_shift_kick;
    t_accu sh_accu_base;
    logic  sh_fill_done;
    logic  sh_shift_done;

    modport master (
        output sh_fill_kick,
        output sh_shift_kick,
        output sh_accu_base,
        input  sh_fill_done,
        input  sh_shift_done
    );

    modport slave (
        input  sh_fill_kick,
        input  sh_shift_kick,
        input  sh_accu_base,
        output sh_fill_done,
        output sh_shift_done
    );

endinterface

// File: rtl/nabp_accu_base_rom.sv
// Per-angle accumulator base ROM, one-cycle registered read.
// Contents come from INIT, word i at bits [i*ACCU_W +: ACCU_W].
module nabp_accu_base_rom
    import nabp_pkg::*;
#(
    parameter int                      DEPTH = 180,
    parameter logic [DEPTH*ACCU_W-1:0] INIT  = '0
) (
    input  logic               clk,
    input  logic [ANGLE_W-1:0] addr,
    output t_accu              q
);

    localparam int IDX_W = $clog2(DEPTH * ACCU_W);

    logic [ANGLE_W-1:0] addr_c;
    logic [IDX_W-1:0]   bit_idx;

    // Out-of-range addresses read word 0 rather than undefined bits.
    always_comb begin
        addr_c  = (int'(addr) < DEPTH) ? addr : '0;
        bit_idx = IDX_W'(addr_c) * IDX_W'(ACCU_W);
    end

    always_ff @(posedge clk) begin
        q <= INIT[bit_idx +: ACCU_W];
    end

endmodule

// File: rtl/nabp_angle_sequencer.sv
// NABP angle sequencer: steps angles 0..ANGLE_LEN-1, loads each angle's accumulator base
// and runs one shifter fill/shift pass per angle. Optional timeout: NABP_ANGLE_SEQ_TIMEOUT_EN.
module nabp_angle_sequencer
    import nabp_pkg::*;
#(
`ifdef NABP_ANGLE_SEQ_TIMEOUT_EN
    parameter int                          TIMEOUT   = 4096,
`endif
    parameter int                          ANGLE_LEN = 180,
    parameter logic [ANGLE_LEN*ACCU_W-1:0] LUT_INIT  = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ANGLE_W-1:0]     angle,
    output logic                   err,
    nabp_angle_sequencer_if.master sh
);

    t_angle_seq_state   state;
    t_angle_seq_state   state_nx;
    logic [ANGLE_W-1:0] angle_nx;
    t_accu              rom_q;

    nabp_accu_base_rom #(
        .DEPTH (ANGLE_LEN),
        .INIT  (LUT_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (angle),
        .q    (rom_q)
    );

`ifdef NABP_ANGLE_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_expire;

    always_comb begin
        tmo_expire = (tmo_cnt == '0) &&
                     (((state == S_FILL_WAIT)  && !sh.sh_fill_done) ||
                      ((state == S_SHIFT_WAIT) && !sh.sh_shift_done));
    end
`endif

    always_comb begin
        state_nx = state;
        angle_nx = angle;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                    angle_nx = '0;
                end
            end
            S_LOAD:       state_nx = S_LATCH;
            S_LATCH:      state_nx = S_FILL_KICK;
            S_FILL_KICK:  state_nx = S_FILL_WAIT;
            S_FILL_WAIT: begin
                if (sh.sh_fill_done) state_nx = S_SHIFT_KICK;
`ifdef NABP_ANGLE_SEQ_TIMEOUT_EN
                else if (tmo_expire) state_nx = S_IDLE;
`endif
            end
            S_SHIFT_KICK: state_nx = S_SHIFT_WAIT;
            S_SHIFT_WAIT: begin
                if (sh.sh_shift_done) state_nx = S_NEXT;
`ifdef NABP_ANGLE_SEQ_TIMEOUT_EN
                else if (tmo_expire) state_nx = S_IDLE;
`endif
            end
            S_NEXT: begin
                if (angle == ANGLE_W'(ANGLE_LEN - 1)) begin
                    state_nx = S_DONE;
                end else begin
                    angle_nx = angle + 1'b1;
                    state_nx = S_LOAD;
                end
            end
            S_DONE:       state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    // Status and kicks are decoded from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            angle            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            sh.sh_fill_kick  <= 1'b0;
            sh.sh_shift_kick <= 1'b0;
            sh.sh_accu_base  <= '0;
        end else begin
            state            <= state_nx;
            angle            <= angle_nx;
            busy             <= !(state_nx inside {S_IDLE, S_DONE});
            done             <= (state_nx == S_DONE);
            sh.sh_fill_kick  <= (state_nx == S_FILL_KICK);
            sh.sh_shift_kick <= (state_nx == S_SHIFT_KICK);
            if (state == S_LATCH) sh.sh_accu_base <= rom_q;
        end
    end

`ifdef NABP_ANGLE_SEQ_TIMEOUT_EN
    // Reload on entry to either wait state; err stays set until the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (((state_nx == S_FILL_WAIT)  && (state != S_FILL_WAIT)) ||
                ((state_nx == S_SHIFT_WAIT) && (state != S_SHIFT_WAIT))) begin
                tmo_cnt <= TMO_W'(TIMEOUT - 1);
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (tmo_expire) begin
                err <= 1'b1;
            end else if ((state == S_IDLE) && start) begin
                err <= 1'b0;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
